// File: rtl/mem_word_responder.sv
// mem_word_responder: word-RAM responder for the cmd_start/cmd_ready/rdata_valid memory protocol
module mem_word_responder #(
  parameter int MEMORY_SIZE  = 4096,
  parameter     MEMORY_FILE  = "",
  parameter int READ_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        input_cmd_start,
  input  logic        input_cmd_write,
  output logic        output_cmd_ready,
  input  logic [31:0] input_addr,
  output logic [31:0] output_rdata,
  output logic        output_rdata_valid,
`ifdef MEM_OOR_ERROR_EN
  output logic        output_oor_error,
`endif
  input  logic [31:0] input_wdata
);
  localparam int AW    = $clog2(MEMORY_SIZE);
  localparam int WORDS = MEMORY_SIZE / 4;
  typedef enum logic {IDLE, READ_WAIT} state_t;
  state_t        r_state, w_next;
  logic [31:0]   r_mem [WORDS];
  logic [AW-3:0] r_idx;
  logic [3:0]    r_cnt;
  logic          r_rd_oor;
  logic [31:0]   r_rdata;
  logic          w_accept, w_done, w_oor, w_unused;
  logic [AW-3:0] w_idx;
  assign w_idx    = input_addr[AW-1:2];
  assign w_accept = input_cmd_start && r_state == IDLE;
  assign w_done   = r_state == READ_WAIT && r_cnt == 4'd0;
`ifdef MEM_OOR_ERROR_EN
  logic r_oor_error;
  assign w_oor            = |input_addr[31:AW];
  assign output_oor_error = r_oor_error;
  assign w_unused         = &{1'b0, input_addr[1:0]};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_oor_error <= 1'b0;
    else if (w_accept && w_oor) r_oor_error <= 1'b1;
`else
  assign w_oor    = 1'b0;
  assign w_unused = &{1'b0, input_addr[1:0], input_addr[31:AW]};
`endif
  always_comb begin
    w_next = (w_accept && !input_cmd_write) ? READ_WAIT : w_done ? IDLE : r_state;
  end
  always_ff @(posedge clk)
    if (rst_n && w_accept && input_cmd_write && !w_oor) r_mem[w_idx] <= input_wdata;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= 4'd0;
      r_idx    <= '0;
      r_rd_oor <= 1'b0;
      r_rdata  <= 32'h0;
    end else begin
      r_state <= w_next;
      if (w_accept && !input_cmd_write) begin
        r_cnt    <= 4'(READ_LATENCY - 1);
        r_idx    <= w_idx;
        r_rd_oor <= w_oor;
      end else if (r_state == READ_WAIT) begin
        r_cnt <= r_cnt - 4'd1;
        if (r_cnt == 4'd0) r_rdata <= r_rd_oor ? 32'h0 : r_mem[r_idx];
      end
    end
  assign output_cmd_ready   = r_state == IDLE;
  assign output_rdata_valid = r_state == IDLE;
  assign output_rdata       = r_rdata;
endmodule

// File: tb/tb_mem_word_responder.sv
// tb_mem_word_responder: self-checking bench for mem_word_responder at latencies 2, 1 and 5
module tb_mem_word_responder;
  localparam int MEM = 4096;
  logic        clk = 0, rst_n = 1;
  logic [2:0]  start = '0, rdy, vld, oor;
  logic        wr = 0;
  logic [31:0] addr = 0, wdata = 0;
  logic [31:0] rd [3];
  logic [31:0] mem_m [3][1024];
  bit          oor_m [3];
  int          written [$];
  int          n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  mem_word_responder #(.READ_LATENCY(2)) u_l2 (
    .clk(clk), .rst_n(rst_n), .input_cmd_start(start[0]), .input_cmd_write(wr),
    .output_cmd_ready(rdy[0]), .input_addr(addr), .output_rdata(rd[0]),
    .output_rdata_valid(vld[0]),
`ifdef MEM_OOR_ERROR_EN
    .output_oor_error(oor[0]),
`endif
    .input_wdata(wdata));
  mem_word_responder #(.READ_LATENCY(1)) u_l1 (
    .clk(clk), .rst_n(rst_n), .input_cmd_start(start[1]), .input_cmd_write(wr),
    .output_cmd_ready(rdy[1]), .input_addr(addr), .output_rdata(rd[1]),
    .output_rdata_valid(vld[1]),
`ifdef MEM_OOR_ERROR_EN
    .output_oor_error(oor[1]),
`endif
    .input_wdata(wdata));
  mem_word_responder #(.READ_LATENCY(5)) u_l5 (
    .clk(clk), .rst_n(rst_n), .input_cmd_start(start[2]), .input_cmd_write(wr),
    .output_cmd_ready(rdy[2]), .input_addr(addr), .output_rdata(rd[2]),
    .output_rdata_valid(vld[2]),
`ifdef MEM_OOR_ERROR_EN
    .output_oor_error(oor[2]),
`endif
    .input_wdata(wdata));
`ifndef MEM_OOR_ERROR_EN
  assign oor = '0;
`endif

  function automatic int lat(input int s);
    return s == 0 ? 2 : s == 1 ? 1 : 5;
  endfunction

  function automatic logic [31:0] model_rd(input int s, input logic [31:0] a);
`ifdef MEM_OOR_ERROR_EN
    if (a >= MEM) return 32'h0;
`endif
    return mem_m[s][(a % MEM) / 4];
  endfunction

  task automatic idle(input int n);
    start = '0;
    wr = 0;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_write(input int s, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] prev;
    prev = rd[s];
    start = '0;
    start[s] = 1;
    wr = 1;
    addr = a;
    wdata = d;
`ifdef MEM_OOR_ERROR_EN
    if (a >= MEM) oor_m[s] = 1;
    else mem_m[s][(a % MEM) / 4] = d;
`else
    mem_m[s][(a % MEM) / 4] = d;
`endif
    @(negedge clk);
    n_chk++;
    if (rdy[s] !== 1'b1 || vld[s] !== 1'b1) begin
      n_fail++;
      $display("FAIL wr_ready_valid dut%0d addr=%h: ready=%b valid=%b, want 1/1", s, a, rdy[s], vld[s]);
    end
    n_chk++;
    if (rd[s] !== prev) begin
      n_fail++;
      $display("FAIL wr_rdata_stable dut%0d addr=%h: rdata=%h, want %h", s, a, rd[s], prev);
    end
`ifdef MEM_OOR_ERROR_EN
    n_chk++;
    if (oor[s] !== oor_m[s]) begin
      n_fail++;
      $display("FAIL wr_oor dut%0d addr=%h: oor=%b, want %b", s, a, oor[s], oor_m[s]);
    end
`endif
  endtask

  task automatic do_read(input int s, input logic [31:0] a, input bit poke);
    logic [31:0] exp;
    int n;
    exp = model_rd(s, a);
`ifdef MEM_OOR_ERROR_EN
    if (a >= MEM) oor_m[s] = 1;
`endif
    start = '0;
    start[s] = 1;
    wr = 0;
    addr = a;
    @(negedge clk);
    start[s] = 0;
    n_chk++;
    if (rdy[s] !== 1'b0 || vld[s] !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_busy dut%0d addr=%h: ready=%b valid=%b, want 0/0", s, a, rdy[s], vld[s]);
    end
    n = 0;
    while (vld[s] !== 1'b1 && n < 32) begin
      if (poke) begin
        start[s] = 1;
        wr = 1;
        wdata = $urandom;
      end
      @(negedge clk);
      n++;
    end
    start[s] = 0;
    wr = 0;
    n_chk++;
    if (n != lat(s)) begin
      n_fail++;
      $display("FAIL rd_latency dut%0d addr=%h: %0d cycles, want %0d", s, a, n, lat(s));
    end
    n_chk++;
    if (rd[s] !== exp) begin
      n_fail++;
      $display("FAIL rd_data dut%0d addr=%h: rdata=%h, want %h", s, a, rd[s], exp);
    end
    n_chk++;
    if (rdy[s] !== 1'b1) begin
      n_fail++;
      $display("FAIL rd_ready dut%0d addr=%h: ready=%b, want 1", s, a, rdy[s]);
    end
`ifdef MEM_OOR_ERROR_EN
    n_chk++;
    if (oor[s] !== oor_m[s]) begin
      n_fail++;
      $display("FAIL rd_oor dut%0d addr=%h: oor=%b, want %b", s, a, oor[s], oor_m[s]);
    end
`endif
  endtask

  task automatic check_reset_values(input string tag);
    for (int s = 0; s < 3; s++) begin
      n_chk++;
      if (rdy[s] !== 1'b1 || vld[s] !== 1'b1 || rd[s] !== 32'h0 || oor[s] !== 1'b0) begin
        n_fail++;
        $display("FAIL %s dut%0d: ready=%b valid=%b rdata=%h oor=%b, want 1/1/0/0",
                 tag, s, rdy[s], vld[s], rd[s], oor[s]);
      end
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 0;
    repeat (2) @(negedge clk);
    check_reset_values("reset_during");
    rst_n = 1;
    @(negedge clk);
    check_reset_values("reset_after");
  endtask

  task automatic test_idle_noop();
    start = '0;
    wr = 1;
    addr = 32'hffffffff;
    wdata = $urandom;
    repeat (3) @(negedge clk);
    check_reset_values("idle_noop");
    wr = 0;
  endtask

  task automatic test_write_read();
    do_write(0, 32'h10, 32'hdeadbeef);
    do_read(0, 32'h10, 0);
  endtask

  task automatic test_back_to_back();
    do_write(0, 32'h0, 32'hcafebebe);
    do_write(0, 32'h4, 32'hdeadbeef);
    do_read(0, 32'h2, 0);
    do_read(0, 32'h4, 0);
  endtask

  task automatic test_latency();
    for (int s = 1; s < 3; s++) begin
      do_write(s, 32'h8, 32'h5a5a0000 + s);
      idle(1);
      do_read(s, 32'h8, 1);
      do_read(s, 32'h8, 0);
    end
  endtask

  task automatic test_random();
    logic [31:0] a;
    int w;
    for (int i = 0; i < 40; i++) begin
      if (written.size() == 0 || $urandom_range(0, 1) == 1) begin
        w = $urandom_range(0, 1023);
        a = 32'(w * 4 + $urandom_range(0, 3));
        do_write(0, a, $urandom);
        written.push_back(w);
      end else begin
        w = written[$urandom_range(0, written.size() - 1)];
        a = 32'(w * 4 + $urandom_range(0, 3));
        if ($urandom_range(0, 3) == 0) a = a + 32'(MEM * $urandom_range(1, 1000));
        do_read(0, a, 0);
      end
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
    end
    idle(1);
  endtask

  task automatic test_wrap_or_oor();
    do_write(0, 32'h0, 32'h0badf00d);
`ifdef MEM_OOR_ERROR_EN
    do_write(0, 32'h1000, 32'h11112222);
    do_read(0, 32'h1000, 0);
    do_read(0, 32'h0, 0);
`else
    do_read(0, 32'h1000, 0);
`endif
  endtask

  task automatic test_reset_mid_read();
    do_write(0, 32'h20, 32'h12345678);
    do_read(0, 32'h20, 0);
    start[0] = 1;
    wr = 0;
    addr = 32'h20;
    @(negedge clk);
    start[0] = 0;
    @(posedge clk);
    #1 rst_n = 0;
    for (int s = 0; s < 3; s++) oor_m[s] = 0;
    #1 check_reset_values("reset_mid_read");
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_chk++;
      if (vld[0] !== 1'b1 || rd[0] !== 32'h0) begin
        n_fail++;
        $display("FAIL no_late_completion cycle %0d: valid=%b rdata=%h, want 1/0", i, vld[0], rd[0]);
      end
    end
    do_read(0, 32'h20, 0);
  endtask

  initial begin
    test_reset();
    test_idle_noop();
    test_write_read();
    test_back_to_back();
    test_latency();
    test_random();
    test_wrap_or_oor();
    test_reset_mid_read();
    idle(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
